// File: rtl/muu_ctrl.sv
// Multiply/divide unit controller: multi-cycle MUL/MULT/MADD/MSUBU, restoring DIV,
// and MFHI/MFLO reads of the architectural hi/lo pair.
module muu_ctrl #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  operation,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        stall,
    output logic [31:0] out,
    output logic        out_valid,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam logic [3:0] OP_MUL   = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MADD  = 4'b0010;
    localparam logic [3:0] OP_MSUBU = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [3:0]  op_q;
    logic [31:0] a_q;        // multiplicand, or dividend/quotient shift register
    logic [31:0] b_q;        // multiplier, or divisor magnitude
    logic [31:0] rem_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] out_q;
    logic        out_valid_q;
    logic        div_zero_q;

    logic [63:0] prod_s_d;
    logic [63:0] prod_u_d;
    logic [63:0] mul_res_d;
    logic [32:0] shifted_d;
    logic [32:0] diff_d;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] quo_fix_d;
    logic [31:0] rem_fix_d;
    logic [31:0] rs_mag_d;
    logic [31:0] rt_mag_d;

    assign prod_s_d = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u_d = {32'd0, a_q} * {32'd0, b_q};

    always_comb begin
        mul_res_d = {hi_q, lo_q};
        case (op_q)
            OP_MUL, OP_MULT: mul_res_d = prod_s_d;
            OP_MADD:         mul_res_d = {hi_q, lo_q} + prod_s_d;
            OP_MSUBU:        mul_res_d = {hi_q, lo_q} - prod_u_d;
            default:         mul_res_d = {hi_q, lo_q};
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign shifted_d = {rem_q, a_q[31]};
    assign diff_d    = shifted_d - {1'b0, b_q};
    assign rem_d     = diff_d[32] ? shifted_d[31:0] : diff_d[31:0];
    assign quo_d     = {a_q[30:0], ~diff_d[32]};

    assign quo_fix_d = q_neg_q ? (32'd0 - a_q) : a_q;
    assign rem_fix_d = r_neg_q ? (32'd0 - rem_q) : rem_q;

    assign rs_mag_d  = rs[31] ? (32'd0 - rs) : rs;
    assign rt_mag_d  = rt[31] ? (32'd0 - rt) : rt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            op_q        <= 4'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            rem_q       <= 32'd0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            out_q       <= 32'd0;
            out_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (operation)
                            OP_MUL, OP_MULT, OP_MADD, OP_MSUBU: begin
                                op_q    <= operation;
                                a_q     <= rs;
                                b_q     <= rt;
                                cnt_q   <= 5'(MUL_CYCLES - 1);
                                state_q <= S_MUL;
                            end
                            OP_DIV: begin
                                if (rt == 32'd0) begin
                                    div_zero_q <= 1'b1;
                                end else begin
                                    op_q    <= operation;
                                    a_q     <= rs_mag_d;
                                    b_q     <= rt_mag_d;
                                    rem_q   <= 32'd0;
                                    q_neg_q <= rs[31] ^ rt[31];
                                    r_neg_q <= rs[31];
                                    cnt_q   <= 5'd31;
                                    state_q <= S_DIV;
                                end
                            end
                            OP_MFHI: begin
                                out_q       <= hi_q;
                                out_valid_q <= 1'b1;
                            end
                            OP_MFLO: begin
                                out_q       <= lo_q;
                                out_valid_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q == 5'd0) begin
                        hi_q    <= mul_res_d[63:32];
                        lo_q    <= mul_res_d[31:0];
                        state_q <= S_IDLE;
                        if (op_q == OP_MUL) begin
                            out_q       <= mul_res_d[31:0];
                            out_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    a_q   <= quo_d;
                    if (cnt_q == 5'd0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_FIX: begin
                    lo_q    <= quo_fix_d;
                    hi_q    <= rem_fix_d;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign stall     = start & busy;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign div_zero  = div_zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
